piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in/serial-out shifter: the transmit-side counterpart to the team's capture register. It accepts an N-bit word through a valid/ready handshake and shifts it out LSB-first on a single serial line. Each bit is held for DIV clock cycles. It sits between a word-wide datapath and a one-wire output, for example a UART-style line, an LED or a pin driver.

Parameters:
N, 8, data word width in bits (N >= 1)
DIV, 4, clock cycles each serial bit is held (DIV >= 1)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
ce  input  1  clock enable; 0 freezes all state (stall)
d  input  N  parallel word to transmit
load_valid  input  1  d is valid and requests transmission
load_ready  output  1  block can accept a word this cycle
sdo  output  1  serial data out; idle level 1
busy  output  1  frame in progress
bit_strobe  output  1  one-cycle pulse in the first cycle each bit appears on sdo
done  output  1  one-cycle pulse after the last bit period ends

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). While rst_n=0: state=IDLE, sdo=1, busy=0, load_ready=0, bit_strobe=0, done=0, shift register=0, counters=0.
- After rst_n deasserts, load_ready=1 from the first ce=1 edge.
- States: IDLE, SHIFT (plus PAR when the optional feature is compiled in).
- IDLE:
  - load_ready=1 (registered; stays 1 while ce=0), busy=0, sdo=1.
  - Handshake occurs on an edge with ce=1, load_valid=1 and load_ready=1. On that edge: shreg<=d, bit_cnt<=0, div_cnt<=0, state<=SHIFT.
  - load_valid with load_ready=0 is ignored; no queuing.
- SHIFT:
  - busy=1, load_ready=0, sdo=shreg[0].
  - div_cnt counts 0..DIV-1 on ce=1 edges.
  - bit_strobe=1 in cycles where div_cnt=0 and ce=1.
  - At div_cnt=DIV-1 (ce=1): div_cnt<=0 and shreg shifts right by 1 (MSB fills 0).
    - If bit_cnt=N-1: go to PAR if compiled in, else IDLE.
    - Otherwise bit_cnt<=bit_cnt+1.
- Latency:
  - If the handshake occurs at edge k, bit0 drives sdo from cycle k+1 for DIV cycles.
  - The frame occupies N*DIV ce-cycles (N*DIV+DIV with parity).
- Frame end:
  - done=1 for exactly one cycle: the first cycle back in IDLE.
  - load_ready=1 in that same cycle, so a back-to-back load is accepted on that edge.
  - Minimum gap between frames: 1 cycle of sdo=1.
- ce=0: all registers hold, including div_cnt, bit_cnt and state. sdo holds its value. bit_strobe=0 and done=0 (pulses are gated by ce). A done pulse pending in a stalled cycle is emitted on the next ce=1 cycle.
- DIV=1: each bit lasts one cycle, and bit_strobe is high every SHIFT cycle.
- N=1: a single bit period, then done.
- Widths:
  - div_cnt width: $clog2(DIV), minimum 1.
  - bit_cnt width: $clog2(N), minimum 1.
  - No counter wraps beyond its terminal value.
- Reset mid-frame: immediate abort. sdo=1 asynchronously, no done pulse, the word is lost.
- Outputs sdo, busy, load_ready and done are registered, with no combinational path from inputs.

Optional Feature:
Macro: PISO_PARITY_EN.
- Defined: after data bit N-1, state PAR drives the even parity bit (XOR of the captured d) for DIV cycles, with bit_strobe at its start. done follows the PAR period. Frame length is (N+1)*DIV.
- Undefined: PAR state, parity register and XOR logic are absent. The frame ends after bit N-1.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release -> sdo=1, busy=0, done=0; load_ready=1 after first edge.
- Basic frame (N=8, DIV=4, ce=1): d=0xA5 handshake at edge k.
  - sdo over 32 cycles = 1,0,1,0,0,1,0,1, each held 4 cycles.
  - 8 bit_strobe pulses.
  - done=1 in cycle k+33; sdo=1 then.
- Back-to-back: load_valid held high with 0x3C then 0xFF.
  - Second word accepted in the done cycle.
  - Exactly one idle cycle of sdo=1 between frames.
  - load_valid ignored while busy.
- Stall: ce=0 for 5 cycles during bit 3 of 0xA5 -> sdo holds 0, no strobes. The frame completes 5 cycles later with an unchanged bit sequence and a single done pulse.
- Mid-frame reset: rst_n=0 during bit 5 -> sdo=1 immediately, busy=0, no done. A new load of 0x01 afterwards transmits correctly.
- PISO_PARITY_EN defined:
  - 0xA5 -> 9th bit=0, done at k+37.
  - 0x07 -> 9th bit=1.

Source files
------------

// File: rtl/piso_serializer.sv
`timescale 1ns/1ps
// piso_serializer
//   Parallel-in/serial-out shifter. Accepts an N-bit word on a valid/ready
//   handshake and shifts it out LSB-first on sdo, each bit held for DIV
//   clock cycles. sdo idles high.
//
//   Optional feature (macro PISO_PARITY_EN): after data bit N-1 an even
//   parity bit (XOR of the captured word) is sent for DIV cycles before done.
//
// Parameters:
//   N   - data word width in bits (>= 1)
//   DIV - clock cycles each serial bit is held (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ce         in   clock enable; 0 freezes all state
//   d          in   parallel word to transmit
//   load_valid in   d is valid and requests transmission
//   load_ready out  a word can be accepted this cycle (registered)
//   sdo        out  serial data, idle 1 (registered)
//   busy       out  frame in progress (registered)
//   bit_strobe out  pulse in the first cycle of each bit on sdo
//   done       out  pulse in the first idle cycle after a frame
module piso_serializer #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [N-1:0] d,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sdo,
  output logic         busy,
  output logic         bit_strobe,
  output logic         done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_shreg;
  logic [N-1:0]    w_shreg_nxt;
  logic [DW-1:0]   r_div_cnt;
  logic [DW-1:0]   w_div_nxt;
  logic [BW-1:0]   r_bit_cnt;
  logic [BW-1:0]   w_bit_nxt;
  logic            r_sdo;
  logic            w_sdo_nxt;
  logic            r_busy;
  logic            r_load_ready;
  logic            r_done;
  logic            w_hs;
  logic            w_div_end;
  logic            w_frame_end;
`ifdef PISO_PARITY_EN
  logic            r_par;
`endif

  // load_ready is only ever 1 in IDLE, so it alone qualifies the handshake.
  assign w_hs      = ce & load_valid & r_load_ready;
  assign w_div_end = (r_div_cnt == DIV_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, shift register and counter update
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_div_nxt   = r_div_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_frame_end = 1'b0;
    if (ce) begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            w_state_nxt = ST_SHIFT;
            w_shreg_nxt = d;
            w_div_nxt   = '0;
            w_bit_nxt   = '0;
          end
        end
        ST_SHIFT: begin
          if (w_div_end) begin
            w_div_nxt   = '0;
            w_shreg_nxt = r_shreg >> 1;
            if (r_bit_cnt == BIT_LAST) begin
`ifdef PISO_PARITY_EN
              w_state_nxt = ST_PAR;
`else
              w_state_nxt = ST_IDLE;
              w_frame_end = 1'b1;
`endif
            end else begin
              w_bit_nxt = r_bit_cnt + BW'(1);
            end
          end else begin
            w_div_nxt = r_div_cnt + DW'(1);
          end
        end
`ifdef PISO_PARITY_EN
        ST_PAR: begin
          if (w_div_end) begin
            w_div_nxt   = '0;
            w_state_nxt = ST_IDLE;
            w_frame_end = 1'b1;
          end else begin
            w_div_nxt = r_div_cnt + DW'(1);
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // sdo is registered, so it is computed from the state being entered
  // rather than decoded from the current state.
  always_comb begin
    w_sdo_nxt = 1'b1;
    case (w_state_nxt)
      ST_SHIFT: w_sdo_nxt = w_shreg_nxt[0];
`ifdef PISO_PARITY_EN
      ST_PAR:   w_sdo_nxt = r_par;
`endif
      default:  w_sdo_nxt = 1'b1;
    endcase
  end

  // Datapath and registered outputs; everything holds while ce=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg      <= '0;
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_sdo        <= 1'b1;
      r_busy       <= 1'b0;
      r_load_ready <= 1'b0;
      r_done       <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else if (ce) begin
      r_shreg      <= w_shreg_nxt;
      r_div_cnt    <= w_div_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_sdo        <= w_sdo_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_load_ready <= (w_state_nxt == ST_IDLE);
      r_done       <= w_frame_end;
`ifdef PISO_PARITY_EN
      if (w_hs) begin
        r_par <= ^d;
      end
`endif
    end
  end

  assign sdo        = r_sdo;
  assign busy       = r_busy;
  assign load_ready = r_load_ready;
  // The done flag is held in r_done across stalls and only shown on a ce=1
  // cycle, so a frame ending just before a stall still yields one pulse.
  assign done       = ce & r_done;
  assign bit_strobe = ce & (r_state != ST_IDLE) & (r_div_cnt == '0);

endmodule

// File: tb/tb_piso_serializer.sv
`timescale 1ns/1ps
// Directed testbench for piso_serializer (N=8, DIV=4). Covers reset,
// basic frame, back-to-back frames, ce stalls (mid-frame and over done),
// mid-frame reset and, when PISO_PARITY_EN is defined, the parity bit.
module tb_piso_serializer;

  localparam int N   = 8;
  localparam int DIV = 4;
`ifdef PISO_PARITY_EN
  localparam int NB  = N + 1;
  localparam logic PEN = 1'b1;
`else
  localparam int NB  = N;
  localparam logic PEN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         ce;
  logic [N-1:0] d;
  logic         load_valid;
  logic         load_ready;
  logic         sdo;
  logic         busy;
  logic         bit_strobe;
  logic         done;

  int checks   = 0;
  int failures = 0;

  piso_serializer #(
    .N   (N),
    .DIV (DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .d          (d),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sdo        (sdo),
    .busy       (busy),
    .bit_strobe (bit_strobe),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after the handshake edge. Walks the frame
  // cycle by cycle and returns in the done cycle (no tick taken there).
  // stall_at: cycle index at which ce is dropped for stall_len cycles;
  // index NB*DIV is the done cycle.
  task automatic expect_frame(input logic [7:0] w, input int stall_at,
                              input int stall_len, output logic [8:0] rx);
    int          strobes;
    logic [8:0]  bits;
    logic        exp_sdo;
    logic        last;
    strobes = 0;
    rx      = '0;
    bits    = {^w, w};
    for (int i = 0; i <= NB * DIV; i++) begin
      last    = (i == NB * DIV);
      exp_sdo = last ? 1'b1 : bits[i / DIV];
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          ce = 1'b0;
          #1;
          check("stall_sdo", 32'(sdo), 32'(exp_sdo));
          check("stall_strobe", 32'(bit_strobe), 32'(0));
          check("stall_done", 32'(done), 32'(0));
          check("stall_busy", 32'(busy), 32'(!last));
          tick();
        end
      end
      ce = 1'b1;
      #1;
      check("sdo", 32'(sdo), 32'(exp_sdo));
      check("busy", 32'(busy), 32'(!last));
      check("done", 32'(done), 32'(last));
      check("load_ready", 32'(load_ready), 32'(last));
      check("strobe", 32'(bit_strobe), 32'(!last && (i % DIV == 0)));
      if (!last) begin
        if (i % DIV == 0) rx[i / DIV] = sdo;
        if (bit_strobe) strobes++;
        tick();
      end
    end
    check("strobe_count", 32'(strobes), 32'(NB));
  endtask

  logic [8:0] rx;

  initial begin
    ce         = 1'b1;
    load_valid = 1'b0;
    d          = '0;
    rst_n      = 1'b0;

    // Reset then idle
    repeat (3) tick();
    check("rst_sdo", 32'(sdo), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ready", 32'(load_ready), 32'(0));
    check("rst_strobe", 32'(bit_strobe), 32'(0));
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(load_ready), 32'(0));
    tick();
    check("ready_after_edge", 32'(load_ready), 32'(1));
    check("idle_sdo", 32'(sdo), 32'(1));
    check("idle_busy", 32'(busy), 32'(0));

    // Basic frame 0xA5
    d = 8'hA5; load_valid = 1'b1;
    tick();
    load_valid = 1'b0; d = '0;
    expect_frame(8'hA5, -1, 0, rx);
    check("rx_a5", 32'(rx), 32'({1'b0, 8'hA5}));
    tick();
    check("done_one_shot", 32'(done), 32'(0));
    check("idle_ready", 32'(load_ready), 32'(1));

    // Back-to-back with load_valid held high; d changes while busy
    d = 8'h3C; load_valid = 1'b1;
    tick();
    d = 8'hFF;
    expect_frame(8'h3C, -1, 0, rx);
    check("rx_3c", 32'(rx), 32'({1'b0, 8'h3C}));
    tick();
    load_valid = 1'b0;
    expect_frame(8'hFF, -1, 0, rx);
    check("rx_ff", 32'(rx), 32'({1'b0, 8'hFF}));
    tick();
    check("b2b_done_clear", 32'(done), 32'(0));

    // Stall of 5 cycles during bit 3 of 0xA5
    d = 8'hA5; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    expect_frame(8'hA5, 3 * DIV + 1, 5, rx);
    check("rx_a5_stall", 32'(rx), 32'({1'b0, 8'hA5}));
    tick();
    check("stall_done_clear", 32'(done), 32'(0));

    // Stall over the done cycle: pulse deferred to the next ce=1 cycle
    d = 8'h81; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    expect_frame(8'h81, NB * DIV, 2, rx);
    check("rx_81", 32'(rx), 32'({1'b0, 8'h81}));
    tick();
    check("deferred_done_clear", 32'(done), 32'(0));

    // Mid-frame reset during bit 5 of 0x5A (bit 5 is 0)
    d = 8'h5A; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (5 * DIV + 1) tick();
    check("pre_rst_sdo", 32'(sdo), 32'(0));
    check("pre_rst_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mrst_sdo", 32'(sdo), 32'(1));
    check("mrst_busy", 32'(busy), 32'(0));
    check("mrst_ready", 32'(load_ready), 32'(0));
    for (int c = 0; c < 2; c++) begin
      tick();
      check("mrst_no_done", 32'(done), 32'(0));
    end
    rst_n = 1'b1;
    tick();
    check("mrst_ready_back", 32'(load_ready), 32'(1));
    check("mrst_done_after", 32'(done), 32'(0));
    d = 8'h01; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    expect_frame(8'h01, -1, 0, rx);
    check("rx_01", 32'(rx), 32'({PEN, 8'h01}));
    tick();

    // Parity-focused word (odd number of ones)
    d = 8'h07; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    expect_frame(8'h07, -1, 0, rx);
    check("rx_07", 32'(rx), 32'({PEN, 8'h07}));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
